uart_fifo: RTL and testbench

Synchronous byte FIFO that buffers traffic between the core's memory-mapped I/O path and the UART. One instance feeds the UART transmitter, which pops through `RE`/`Empty`/`dout`. A second instance absorbs received bytes, which the UART pushes through `WE`/`Full`/`din`. The FIFO is first-word-fall-through: the head byte is visible on `dout` whenever `Empty` is low. It also reports occupancy and sticky overflow/underflow errors for status reads.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_fifo_if.sv | 43 ++++
 rtl/uart_fifo_mem.sv | 40 ++++
 rtl/uart_fifo.sv | 96 +++++++++
 tb/tb_uart_fifo.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared constants and types for the UART byte path.
//  Contents : UART_DATA_W      - byte width
//             UART_FIFO_DEPTH  - default FIFO depth
//             uart_byte_t      - one UART byte
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;
  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;
endpackage

`default_nettype wire

// File: rtl/uart_fifo_if.sv
// ============================================================================
//  Module   : uart_fifo_if
//  Purpose  : Push/pop/status bundle between a FIFO user and uart_fifo.
//  Signals  : WE, din        - push request and data
//             RE, dout       - pop request and head data (FWFT)
//             Empty, Full    - occupancy flags
//             count          - occupancy 0..DEPTH
//             clr_err        - clears sticky error flags
//             ovf, udf       - sticky overflow / underflow
//  Modports : master - FIFO user, slave - the FIFO itself
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             WE;
  logic [WIDTH-1:0] din;
  logic             RE;
  logic [WIDTH-1:0] dout;
  logic             Empty;
  logic             Full;
  logic [AW:0]      count;
  logic             clr_err;
  logic             ovf;
  logic             udf;

  modport master (
    output WE, din, RE, clr_err,
    input  dout, Empty, Full, count, ovf, udf
  );

  modport slave (
    input  WE, din, RE, clr_err,
    output dout, Empty, Full, count, ovf, udf
  );
endinterface

`default_nettype wire

// File: rtl/uart_fifo_mem.sv
// ============================================================================
//  Module   : fifo_mem
//  Purpose  : DEPTH x WIDTH register array, one synchronous write port and
//             one asynchronous read port. Contents are never reset.
//  Ports    : clk    - write clock
//             we     - write enable
//             waddr  - write index
//             wdata  - write data
//             raddr  - read index
//             rdata  - combinational read data
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             we,
  input  wire logic [AW-1:0]    waddr,
  input  wire logic [WIDTH-1:0] wdata,
  input  wire logic [AW-1:0]    raddr,
  output logic      [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/uart_fifo.sv
// ============================================================================
//  Module   : uart_fifo
//  Purpose  : First-word-fall-through synchronous byte FIFO between the
//             memory-mapped I/O path and the UART, with occupancy and sticky
//             overflow/underflow reporting.
//  Ports    : CLK  - clock, rising edge
//             RST  - asynchronous active-high reset
//             bus  - uart_fifo_if.slave (push, pop, status, error flags)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = UART_DATA_W,
  parameter int DEPTH = UART_FIFO_DEPTH
) (
  input  wire logic    CLK,
  input  wire logic    RST,
  uart_fifo_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the index bits coincide.
  logic [AW:0]      r_wp;
  logic [AW:0]      r_rp;
  logic             r_ovf;
  logic             r_udf;

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_rdata;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);

  // Acceptance depends only on registered flags, so a pop in the same cycle
  // never makes room for a push while full.
  assign w_push  = bus.WE & ~w_full;
  assign w_pop   = bus.RE & ~w_empty;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      // A new error event takes priority over a clear in the same cycle.
      if (bus.WE && w_full) begin
        r_ovf <= 1'b1;
      end else if (bus.clr_err) begin
        r_ovf <= 1'b0;
      end
      if (bus.RE && w_empty) begin
        r_udf <= 1'b1;
      end else if (bus.clr_err) begin
        r_udf <= 1'b0;
      end
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (CLK),
    .we    (w_push),
    .waddr (r_wp[AW-1:0]),
    .wdata (bus.din),
    .raddr (r_rp[AW-1:0]),
    .rdata (w_rdata)
  );

  assign bus.dout  = w_rdata;
  assign bus.Empty = w_empty;
  assign bus.Full  = w_full;
  assign bus.count = r_wp - r_rp;
  assign bus.ovf   = r_ovf;
  assign bus.udf   = r_udf;

endmodule

`default_nettype wire

// File: tb/tb_uart_fifo.sv
// ============================================================================
//  Module   : tb_uart_fifo
//  Purpose  : Self-checking bench for uart_fifo against a queue-based
//             reference model of the FIFO behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_fifo;
  import uart_pkg::*;

  localparam int DEPTH = UART_FIFO_DEPTH;

  logic CLK;
  logic RST;

  uart_fifo_if #(.WIDTH(UART_DATA_W), .DEPTH(DEPTH)) bus ();

  uart_fifo #(.WIDTH(UART_DATA_W), .DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: contents as a queue plus the two sticky flags.
  uart_byte_t q[$];
  bit         m_ovf;
  bit         m_udf;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("count", 32'(bus.count), 32'(q.size()));
    chk("Empty", 32'(bus.Empty), 32'(q.size() == 0));
    chk("Full",  32'(bus.Full),  32'(q.size() == DEPTH));
    chk("ovf",   32'(bus.ovf),   32'(m_ovf));
    chk("udf",   32'(bus.udf),   32'(m_udf));
    if (q.size() != 0) begin
      chk("dout", 32'(bus.dout), 32'(q[0]));
    end
  endtask

  // Applies the currently driven inputs across one rising edge, updates the
  // model from the pre-edge occupancy, then checks the DUT 1 ns later.
  task automatic cycle();
    int         sz;
    bit         we;
    bit         re;
    bit         clr;
    uart_byte_t d;
    sz  = q.size();
    we  = bus.WE;
    re  = bus.RE;
    clr = bus.clr_err;
    d   = bus.din;
    @(posedge CLK);
    #1;
    if (re && sz > 0)     void'(q.pop_front());
    if (we && sz < DEPTH) q.push_back(d);
    if (we && sz == DEPTH) m_ovf = 1'b1;
    else if (clr)          m_ovf = 1'b0;
    if (re && sz == 0)     m_udf = 1'b1;
    else if (clr)          m_udf = 1'b0;
    check_state();
  endtask

  task automatic drive(input bit we, input uart_byte_t d, input bit re, input bit clr);
    bus.WE      = we;
    bus.din     = d;
    bus.RE      = re;
    bus.clr_err = clr;
  endtask

  initial begin
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    m_ovf = 1'b0;
    m_udf = 1'b0;
    RST   = 1'b1;
    #2;
    check_state();
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) cycle();

    // Three pushes, then three pops in order.
    drive(1'b1, 8'h41, 1'b0, 1'b0); cycle();
    chk("dout_first", 32'(bus.dout), 32'h41);
    drive(1'b1, 8'h42, 1'b0, 1'b0); cycle();
    drive(1'b1, 8'h43, 1'b0, 1'b0); cycle();
    chk("pop0", 32'(bus.dout), 32'h41);
    drive(1'b0, 8'h00, 1'b1, 1'b0); cycle();
    chk("pop1", 32'(bus.dout), 32'h42);
    cycle();
    chk("pop2", 32'(bus.dout), 32'h43);
    cycle();
    chk("empty_after_3", 32'(bus.Empty), 32'h1);

    // Fill to 16, reject a 17th push, drain, clear the error.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, uart_byte_t'(i), 1'b0, 1'b0); cycle();
    end
    chk("full16", 32'(bus.Full), 32'h1);
    chk("count16", 32'(bus.count), 32'd16);
    drive(1'b1, 8'hFF, 1'b0, 1'b0); cycle();
    chk("ovf17", 32'(bus.ovf), 32'h1);
    chk("count_hold", 32'(bus.count), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain", 32'(bus.dout), 32'(i));
      drive(1'b0, 8'h00, 1'b1, 1'b0); cycle();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1); cycle();
    chk("ovf_clr", 32'(bus.ovf), 32'h0);

    // Simultaneous push/pop while full: pop wins, 0xAA is dropped.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, uart_byte_t'($urandom_range(0, 8'hA9)), 1'b0, 1'b0); cycle();
    end
    drive(1'b1, 8'hAA, 1'b1, 1'b0); cycle();
    chk("count15", 32'(bus.count), 32'd15);
    chk("ovf_wr", 32'(bus.ovf), 32'h1);
    for (int i = 0; i < DEPTH - 1; i++) begin
      chk("no_aa", 32'(bus.dout == 8'hAA), 32'h0);
      drive(1'b0, 8'h00, 1'b1, 1'b0); cycle();
    end
    // Same-cycle set and clear: set wins for udf, ovf clears.
    drive(1'b0, 8'h00, 1'b1, 1'b1); cycle();
    chk("udf_set_wins", 32'(bus.udf), 32'h1);
    drive(1'b0, 8'h00, 1'b0, 1'b1); cycle();

    // Simultaneous push/pop while empty: push wins, udf set.
    drive(1'b1, 8'h77, 1'b1, 1'b0); cycle();
    chk("udf_empty", 32'(bus.udf), 32'h1);
    chk("push_empty", 32'(bus.dout), 32'h77);
    drive(1'b0, 8'h00, 1'b1, 1'b1); cycle();

    // Random traffic around half-full, long enough for many pointer wraps.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, uart_byte_t'($urandom), 1'b0, 1'b0); cycle();
    end
    for (int i = 0; i < 400; i++) begin
      bit we;
      bit re;
      we = (q.size() < 6)  ? 1'b1 : ($urandom_range(0, 9) != 0);
      re = (q.size() > 10) ? 1'b1 : ($urandom_range(0, 9) != 0);
      drive(we, uart_byte_t'($urandom), re, 1'b0); cycle();
    end
    while (q.size() != 0) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0); cycle();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1); cycle();

    // Asynchronous reset mid-cycle discards contents immediately.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, uart_byte_t'(8'h10 + i), 1'b0, 1'b0); cycle();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    chk("rst_empty", 32'(bus.Empty), 32'h1);
    chk("rst_count", 32'(bus.count), 32'h0);
    #2;
    RST = 1'b0;
    drive(1'b1, 8'h5A, 1'b0, 1'b0); cycle();
    chk("post_rst", 32'(bus.dout), 32'h5A);
    drive(1'b0, 8'h00, 1'b1, 1'b0); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
